// File: rtl/usb_slfifo_pkg.sv
// Shared types and constants for the FX2 Slave FIFO reader/writer pair.
package usb_slfifo_pkg;

    localparam int FD_W = 16;

    localparam logic [1:0] EP2 = 2'b00;
    localparam logic [1:0] EP4 = 2'b01;
    localparam logic [1:0] EP6 = 2'b10;
    localparam logic [1:0] EP8 = 2'b11;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ADDR,
        RD_OE,
        RD_READ,
        RD_REL
    } rd_state_t;

endpackage

// File: rtl/slfifo_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO; pointers carry an extra MSB
// so full/empty/level fall out of a plain subtraction.
module slfifo_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    // Push is refused when full even if a pop happens on the same edge.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/usb_slfifo_reader.sv
// FX2 Slave FIFO synchronous-read master draining an OUT endpoint into a stream.
// Optional macro USB_SLFIFO_RD_CNT_EN adds RD_COUNT and OVR_STALL.
module usb_slfifo_reader
    import usb_slfifo_pkg::*;
#(
    parameter logic [1:0] EP_ADDR   = EP2,
    parameter int         DEPTH     = 16,
    parameter int         BURST_LEN = 256
) (
    input  logic                   USB_IFCLK,
    input  logic                   USB_RESET2,
    input  logic                   REQ,
    output logic                   BUSY,
    input  logic [FD_W-1:0]        FD,
    input  logic                   EF_N,
    output logic                   SLRD_N,
    output logic                   SLOE_N,
    output logic [1:0]             FIFOADR,
    output logic [FD_W-1:0]        M_DATA,
    output logic                   M_VALID,
    input  logic                   M_READY,
    output logic [$clog2(DEPTH):0] LEVEL
`ifdef USB_SLFIFO_RD_CNT_EN
    ,
    output logic [31:0]            RD_COUNT,
    output logic                   OVR_STALL
`endif
);

    localparam logic [15:0] BURST_MAX = 16'(BURST_LEN);

    rd_state_t   state;
    logic [15:0] burst_cnt;
    logic        burst_done;
    logic        full;
    logic        empty;
    logic        push;

    assign FIFOADR    = EP_ADDR;
    assign burst_done = (burst_cnt == BURST_MAX);
    // Strobe is combinational on EF_N so an empty FX2 FIFO is never popped.
    assign SLRD_N     = ~((state == RD_READ) & EF_N & ~full & ~burst_done);
    assign push       = ~SLRD_N;
    assign M_VALID    = ~empty;

    slfifo_sync_fifo #(
        .WIDTH (FD_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (USB_IFCLK),
        .rst_n (USB_RESET2),
        .push  (push),
        .din   (FD),
        .pop   (M_READY),
        .dout  (M_DATA),
        .full  (full),
        .empty (empty),
        .level (LEVEL)
    );

    always_ff @(posedge USB_IFCLK or negedge USB_RESET2) begin
        if (!USB_RESET2) begin
            state     <= RD_IDLE;
            BUSY      <= 1'b0;
            SLOE_N    <= 1'b1;
            burst_cnt <= '0;
        end else begin
            if (push)
                burst_cnt <= burst_cnt + 1'b1;
            case (state)
                RD_IDLE: begin
                    if (REQ && EF_N) begin
                        state     <= RD_ADDR;
                        BUSY      <= 1'b1;
                        burst_cnt <= '0;
                    end
                end
                RD_ADDR: begin
                    state  <= RD_OE;
                    SLOE_N <= 1'b0;
                end
                RD_OE: state <= RD_READ;
                RD_READ: begin
                    // A strobe already asserted this cycle still completes on exit.
                    if (!EF_N || !REQ || burst_done) begin
                        state  <= RD_REL;
                        SLOE_N <= 1'b1;
                    end
                end
                RD_REL: begin
                    state <= RD_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state  <= RD_IDLE;
                    BUSY   <= 1'b0;
                    SLOE_N <= 1'b1;
                end
            endcase
        end
    end

`ifdef USB_SLFIFO_RD_CNT_EN
    logic [6:0] stall_cnt;
    logic       stall;

    assign stall = (state == RD_READ) & full;

    always_ff @(posedge USB_IFCLK or negedge USB_RESET2) begin
        if (!USB_RESET2) begin
            RD_COUNT  <= '0;
            OVR_STALL <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (push)
                RD_COUNT <= RD_COUNT + 1'b1;
            // Sticky flag fires on the 65th consecutive stalled cycle.
            if (stall) begin
                if (stall_cnt == 7'd64)
                    OVR_STALL <= 1'b1;
                else
                    stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_usb_slfifo_reader.sv
// Directed bench for usb_slfifo_reader: FX2 FIFO model, stream scoreboard, trace checks.
module tb_usb_slfifo_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        busy;
    logic [15:0] fd;
    logic        ef_n;
    logic        slrd_n;
    logic        sloe_n;
    logic [1:0]  fifoadr;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [4:0]  level;

    logic        req2 = 1'b0;
    logic        busy2;
    logic [15:0] fd2;
    logic        slrd2_n;
    logic        sloe2_n;
    logic [1:0]  fifoadr2;
    logic [15:0] m_data2;
    logic        m_valid2;
    logic [4:0]  level2;

`ifdef USB_SLFIFO_RD_CNT_EN
    logic [31:0] rd_count, rd_count2;
    logic        ovr_stall, ovr_stall2;
`endif

    int  total = 0;
    int  popped = 0;
    int  popped2 = 0;
    bit  ef_hold = 1'b0;
    bit  sb_en = 1'b1;
    int  exp_word = 1;
    int  sb_cnt = 0;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    // FX2 model: FD always shows the word that the next strobe pops.
    assign ef_n = (total != popped) && !ef_hold;
    assign fd   = 16'(popped + 1);
    assign fd2  = 16'(popped2 + 1);

    always @(posedge clk) begin
        if (!slrd_n)  popped  <= popped + 1;
        if (!slrd2_n) popped2 <= popped2 + 1;
    end

    usb_slfifo_reader #(.EP_ADDR(2'b00), .DEPTH(16), .BURST_LEN(256)) dut (
        .USB_IFCLK(clk), .USB_RESET2(rst_n), .REQ(req), .BUSY(busy), .FD(fd),
        .EF_N(ef_n), .SLRD_N(slrd_n), .SLOE_N(sloe_n), .FIFOADR(fifoadr),
        .M_DATA(m_data), .M_VALID(m_valid), .M_READY(m_ready), .LEVEL(level)
`ifdef USB_SLFIFO_RD_CNT_EN
        , .RD_COUNT(rd_count), .OVR_STALL(ovr_stall)
`endif
    );

    usb_slfifo_reader #(.EP_ADDR(2'b10), .DEPTH(16), .BURST_LEN(4)) dut_b (
        .USB_IFCLK(clk), .USB_RESET2(rst_n), .REQ(req2), .BUSY(busy2), .FD(fd2),
        .EF_N(1'b1), .SLRD_N(slrd2_n), .SLOE_N(sloe2_n), .FIFOADR(fifoadr2),
        .M_DATA(m_data2), .M_VALID(m_valid2), .M_READY(1'b1), .LEVEL(level2)
`ifdef USB_SLFIFO_RD_CNT_EN
        , .RD_COUNT(rd_count2), .OVR_STALL(ovr_stall2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Stream scoreboard: words must leave in exactly the order the FX2 supplied them.
    always @(negedge clk) begin
        #2;
        if (sb_en && m_valid && m_ready) begin
            chk("m_data", 32'(m_data), 32'(exp_word));
            exp_word++;
            sb_cnt++;
        end
    end

    task automatic wait_stb(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #1;
            if (!slrd_n) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (popped == total && level == 0 && !busy) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        logic [11:0] btr, stb, oe;
        logic [17:0] btr2, stb2;
        logic [15:0] first2;
        bit          got2;
        int          n;
        int          base;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_slrd", 32'(slrd_n), 32'd1);
        chk("rst_sloe", 32'(sloe_n), 32'd1);
        chk("rst_adr", 32'(fifoadr), 32'd0);
        chk("rst_adr_b", 32'(fifoadr2), 32'd2);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_level_b", 32'(level2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic read: 5 words, ADDR, OE, 5 strobes, EF drop, REL.
        @(negedge clk);
        total = 5; req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            btr[i] = busy; stb[i] = ~slrd_n; oe[i] = ~sloe_n;
        end
        req = 1'b0;
        chk("basic_busy", 32'(btr), 32'h1ff);
        chk("basic_stb", 32'(stb), 32'h07c);
        chk("basic_oe", 32'(oe), 32'h0fe);
        chk("basic_cnt", 32'(sb_cnt), 32'd5);
        chk("basic_level", 32'(level), 32'd0);

        // Burst limit on the BURST_LEN=4 instance.
        got2 = 1'b0; first2 = '0;
        req2 = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk); #1;
            btr2[i] = busy2; stb2[i] = ~slrd2_n;
            if (m_valid2 && !got2) begin got2 = 1'b1; first2 = m_data2; end
        end
        req2 = 1'b0;
        chk("burst_busy", 32'(btr2), 32'h1feff);
        chk("burst_stb", 32'(stb2), 32'h0783c);
        chk("burst_data", 32'(first2), 32'h1);

        // Empty mid-burst: EF drop kills the strobe and ends the tenure.
        @(negedge clk); #1;
        total += 10; req = 1'b1;
        wait_stb("mid_first_stb");
        ef_hold = 1'b1; #1;
        chk("mid_no_stb", 32'(slrd_n), 32'd1);
        @(negedge clk); #1;
        ef_hold = 1'b0;
        chk("mid_rel", {29'd0, busy, sloe_n, slrd_n}, 32'h7);
        wait_stb("mid_retenure");
        wait_drain("mid_drain", 200);
        req = 1'b0;
        chk("mid_cnt", 32'(sb_cnt), 32'd15);

        // Back-pressure: buffer fills, strobe holds, 3 slots free 3 strobes.
        m_ready = 1'b0; total += 40; req = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (!slrd_n) n++;
        end
        chk("bp_fill", 32'(n), 32'd16);
        chk("bp_level", 32'(level), 32'd16);
        chk("bp_hold", {30'd0, busy, slrd_n}, 32'h3);
        m_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (!slrd_n) n++;
            if (i == 2) m_ready = 1'b0;
        end
        chk("bp_resume", 32'(n), 32'd3);
        chk("bp_level2", 32'(level), 32'd16);
        m_ready = 1'b1;
        wait_drain("bp_drain", 300);
        req = 1'b0;
        chk("bp_cnt", 32'(sb_cnt), 32'd55);

        // Reset between edges during READ.
        sb_en = 1'b0;
        m_ready = 1'b0; total += 20; req = 1'b1;
        wait_stb("rst_stb");
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_level", 32'(level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", {29'd0, sloe_n, slrd_n, busy}, 32'h6);
        chk("arst_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; req = 1'b0;
        #1;
        chk("post_rst_level", 32'(level), 32'd0);

`ifdef USB_SLFIFO_RD_CNT_EN
        chk("cnt_rst", rd_count, 32'd0);
        chk("ovr_rst", 32'(ovr_stall), 32'd0);
        base = popped;
        m_ready = 1'b1; total += 300; req = 1'b1;
        wait_drain("cnt_drain", 1000);
        req = 1'b0;
        chk("cnt_val", rd_count, 32'(popped - base));
        m_ready = 1'b0; total += 200; req = 1'b1;
        repeat (60) @(negedge clk);
        #1;
        chk("ovr_early", 32'(ovr_stall), 32'd0);
        repeat (40) @(negedge clk);
        #1;
        chk("ovr_set", 32'(ovr_stall), 32'd1);
        req = 1'b0;
`endif

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
